// File: rtl/e203_exu_commit_arb_pkg.sv
// Shared definitions for the EXU commit/flush arbiter: FSM encoding and the
// default flush-operand width.
package e203_exu_commit_arb_pkg;

    localparam int E203_PC_SIZE = 32;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } commit_arb_state_e;

endpackage

// File: rtl/e203_exu_commit_prio.sv
// Combinational lane priority logic: contiguous valid prefix, oldest
// eligible flush lane, and the mask of lanes younger than a given index.
module e203_exu_commit_prio
    import e203_exu_commit_arb_pkg::*;
#(
    parameter int NLANE = 2,
    parameter int LW    = 1
) (
    input  logic [NLANE-1:0] lane_valid,
    input  logic [NLANE-1:0] lane_flush,
    input  logic [LW-1:0]    kill_idx,
    output logic [NLANE-1:0] prefix_mask,
    output logic             win_vld,
    output logic [LW-1:0]    win_idx,
    output logic [NLANE-1:0] younger_mask
);

    logic prefix_run;

    always_comb begin
        prefix_run  = 1'b1;
        prefix_mask = '0;
        for (int i = 0; i < NLANE; i++) begin
            prefix_run     = prefix_run & lane_valid[i];
            prefix_mask[i] = prefix_run;
        end
    end

    // Scan from the youngest lane down so the oldest eligible lane wins;
    // a lane outside the valid prefix is never eligible.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = NLANE - 1; i >= 0; i--) begin
            if (prefix_mask[i] && lane_flush[i]) begin
                win_vld = 1'b1;
                win_idx = LW'(i);
            end
        end
    end

    always_comb begin
        younger_mask = '0;
        for (int i = 0; i < NLANE; i++) begin
            younger_mask[i] = (i > int'(kill_idx));
        end
    end

endmodule

// File: rtl/e203_exu_commit_arb.sv
// Multi-lane commit and flush arbiter: picks one flush source, holds its
// operands until the IFU acknowledges, and produces commit-ready/kill masks.
module e203_exu_commit_arb
    import e203_exu_commit_arb_pkg::*;
#(
    parameter int PC_SIZE = E203_PC_SIZE,
    parameter int NLANE   = 2,
    parameter int LW      = (NLANE > 1) ? $clog2(NLANE) : 1,
    parameter int CW      = $clog2(NLANE + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NLANE-1:0]         lane_valid,
    output logic [NLANE-1:0]         lane_ready,
    input  logic [NLANE-1:0]         lane_flush,
    input  logic [NLANE*PC_SIZE-1:0] lane_op1,
    input  logic [NLANE*PC_SIZE-1:0] lane_op2,
    input  logic                     excp_flush_req,
    input  logic [PC_SIZE-1:0]       excp_op1,
    input  logic [PC_SIZE-1:0]       excp_op2,
    output logic                     pipe_flush_req,
    input  logic                     pipe_flush_ack,
    output logic [PC_SIZE-1:0]       pipe_flush_add_op1,
    output logic [PC_SIZE-1:0]       pipe_flush_add_op2,
    output logic                     flush_pulse,
    output logic                     flush_src_excp,
    output logic [NLANE-1:0]         lane_kill,
    output logic [CW-1:0]            cmt_cnt,
    output logic                     flush_busy
);

    commit_arb_state_e state_q, state_d;
    logic [LW-1:0]      win_q, win_d;
    logic [PC_SIZE-1:0] op1_q, op1_d;
    logic [PC_SIZE-1:0] op2_q, op2_d;
    logic               src_excp_q, src_excp_d;
    logic [CW-1:0]      cmt_cnt_q, cmt_cnt_d;

    logic [PC_SIZE-1:0] lane_op1_arr [NLANE];
    logic [PC_SIZE-1:0] lane_op2_arr [NLANE];
    logic [NLANE-1:0]   prefix_mask;
    logic [NLANE-1:0]   younger_mask;
    logic               win_vld;
    logic [LW-1:0]      win_idx;
    logic [LW-1:0]      sel_idx;

    for (genvar g = 0; g < NLANE; g++) begin : g_unpack
        assign lane_op1_arr[g] = lane_op1[g*PC_SIZE +: PC_SIZE];
        assign lane_op2_arr[g] = lane_op2[g*PC_SIZE +: PC_SIZE];
    end

    // Kill mask is taken relative to the held winner while waiting for ack.
    assign sel_idx = (state_q == WAIT_ACK) ? win_q : win_idx;

    e203_exu_commit_prio #(
        .NLANE(NLANE),
        .LW   (LW)
    ) u_prio (
        .lane_valid  (lane_valid),
        .lane_flush  (lane_flush),
        .kill_idx    (sel_idx),
        .prefix_mask (prefix_mask),
        .win_vld     (win_vld),
        .win_idx     (win_idx),
        .younger_mask(younger_mask)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            win_q      <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            src_excp_q <= 1'b0;
            cmt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            src_excp_q <= src_excp_d;
            cmt_cnt_q  <= cmt_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        src_excp_d = src_excp_q;
        cmt_cnt_d  = '0;
        for (int i = 0; i < NLANE; i++) begin
            cmt_cnt_d = cmt_cnt_d + CW'(lane_valid[i] & lane_ready[i]);
        end
        case (state_q)
            IDLE: begin
                if ((excp_flush_req || win_vld) && !pipe_flush_ack) begin
                    state_d    = WAIT_ACK;
                    win_d      = excp_flush_req ? '0 : win_idx;
                    op1_d      = pipe_flush_add_op1;
                    op2_d      = pipe_flush_add_op2;
                    src_excp_d = excp_flush_req;
                end
            end
            WAIT_ACK: begin
                if (pipe_flush_ack) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        pipe_flush_req     = 1'b0;
        pipe_flush_add_op1 = '0;
        pipe_flush_add_op2 = '0;
        flush_src_excp     = 1'b0;
        lane_ready         = '0;
        case (state_q)
            IDLE: begin
                if (excp_flush_req) begin
                    pipe_flush_req     = 1'b1;
                    pipe_flush_add_op1 = excp_op1;
                    pipe_flush_add_op2 = excp_op2;
                    flush_src_excp     = 1'b1;
                end else if (win_vld) begin
                    // Older lanes retire now; the winner retires only with ack.
                    pipe_flush_req     = 1'b1;
                    pipe_flush_add_op1 = lane_op1_arr[win_idx];
                    pipe_flush_add_op2 = lane_op2_arr[win_idx];
                    lane_ready         = prefix_mask & ~younger_mask;
                    lane_ready[win_idx] = pipe_flush_ack;
                end else begin
                    lane_ready = prefix_mask;
                end
            end
            WAIT_ACK: begin
                pipe_flush_req     = 1'b1;
                pipe_flush_add_op1 = op1_q;
                pipe_flush_add_op2 = op2_q;
                flush_src_excp     = src_excp_q;
                if (pipe_flush_ack && !src_excp_q) begin
                    lane_ready[win_q] = 1'b1;
                end
            end
        endcase
        flush_pulse = pipe_flush_req & pipe_flush_ack;
        lane_kill   = '0;
        if (flush_pulse) begin
            lane_kill = flush_src_excp ? '1 : younger_mask;
        end
    end

    assign cmt_cnt    = cmt_cnt_q;
    assign flush_busy = (state_q == WAIT_ACK);

    logic [NLANE-1:0] ready_plus1;
    assign ready_plus1 = lane_ready + NLANE'(1);

    a_ready_prefix: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == IDLE) |-> ((lane_ready & ready_plus1) == '0));
    a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (rst_n && pipe_flush_req && !pipe_flush_ack) |=> pipe_flush_req);
    a_ops_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (rst_n && pipe_flush_req && !pipe_flush_ack) |=>
            ($stable(pipe_flush_add_op1) && $stable(pipe_flush_add_op2)));

endmodule

// File: tb/tb_e203_exu_commit_arb.sv
// Directed scoreboard bench for the commit/flush arbiter (NLANE=2, PC_SIZE=32).
module tb_e203_exu_commit_arb;

    localparam int PC_SIZE = 32;
    localparam int NLANE   = 2;
    localparam int CW      = 2;

    logic                     clk;
    logic                     rst_n;
    logic [NLANE-1:0]         lane_valid;
    logic [NLANE-1:0]         lane_ready;
    logic [NLANE-1:0]         lane_flush;
    logic [NLANE*PC_SIZE-1:0] lane_op1;
    logic [NLANE*PC_SIZE-1:0] lane_op2;
    logic                     excp_flush_req;
    logic [PC_SIZE-1:0]       excp_op1;
    logic [PC_SIZE-1:0]       excp_op2;
    logic                     pipe_flush_req;
    logic                     pipe_flush_ack;
    logic [PC_SIZE-1:0]       pipe_flush_add_op1;
    logic [PC_SIZE-1:0]       pipe_flush_add_op2;
    logic                     flush_pulse;
    logic                     flush_src_excp;
    logic [NLANE-1:0]         lane_kill;
    logic [CW-1:0]            cmt_cnt;
    logic                     flush_busy;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    e203_exu_commit_arb #(
        .PC_SIZE(PC_SIZE),
        .NLANE  (NLANE)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .lane_valid        (lane_valid),
        .lane_ready        (lane_ready),
        .lane_flush        (lane_flush),
        .lane_op1          (lane_op1),
        .lane_op2          (lane_op2),
        .excp_flush_req    (excp_flush_req),
        .excp_op1          (excp_op1),
        .excp_op2          (excp_op2),
        .pipe_flush_req    (pipe_flush_req),
        .pipe_flush_ack    (pipe_flush_ack),
        .pipe_flush_add_op1(pipe_flush_add_op1),
        .pipe_flush_add_op2(pipe_flush_add_op2),
        .flush_pulse       (flush_pulse),
        .flush_src_excp    (flush_src_excp),
        .lane_kill         (lane_kill),
        .cmt_cnt           (cmt_cnt),
        .flush_busy        (flush_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] flush,
                                 input logic [31:0] l0_op1, input logic [31:0] l0_op2,
                                 input logic [31:0] l1_op1, input logic [31:0] l1_op2,
                                 input logic excp, input logic [31:0] e_op1,
                                 input logic [31:0] e_op2, input logic ack);
        lane_valid     = valid;
        lane_flush     = flush;
        lane_op1       = {l1_op1, l0_op1};
        lane_op2       = {l1_op2, l0_op2};
        excp_flush_req = excp;
        excp_op1       = e_op1;
        excp_op2       = e_op2;
        pipe_flush_ack = ack;
    endtask

    task automatic idleInputs();
        applyStimulus(2'b00, 2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic expect1(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    function automatic logic [31:0] observe(input string tag);
        if (tag == "req")   return 32'(pipe_flush_req);
        if (tag == "op1")   return pipe_flush_add_op1;
        if (tag == "op2")   return pipe_flush_add_op2;
        if (tag == "ready") return 32'(lane_ready);
        if (tag == "kill")  return 32'(lane_kill);
        if (tag == "pulse") return 32'(flush_pulse);
        if (tag == "src")   return 32'(flush_src_excp);
        if (tag == "cnt")   return 32'(cmt_cnt);
        if (tag == "busy")  return 32'(flush_busy);
        return 'x;
    endfunction

    // Sample mid-cycle, well clear of the rising edge.
    task automatic checkOutput(input string step);
        exp_t        e;
        logic [31:0] obs;
        #3;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            obs = observe(e.tag);
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("[TB] FAIL %s.%s observed=%0h expected=%0h", step, e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idleInputs();
        tick();
        tick();
        rst_n = 1'b1;

        expect1("req", 0); expect1("op1", 0); expect1("op2", 0);
        expect1("ready", 0); expect1("kill", 0); expect1("pulse", 0);
        expect1("src", 0); expect1("cnt", 0); expect1("busy", 0);
        checkOutput("reset");

        // Plain retire of both lanes.
        tick();
        applyStimulus(2'b11, 2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 1'b0);
        expect1("ready", 2'b11); expect1("req", 0); expect1("pulse", 0);
        checkOutput("retire");
        tick();
        idleInputs();
        expect1("cnt", 2); expect1("ready", 0);
        checkOutput("retire_cnt");

        // Blocked flush lane: invalid lane 0 below a flushing lane 1.
        tick();
        applyStimulus(2'b10, 2'b10, 0, 0, 32'h1234, 32'h4, 1'b0, 0, 0, 1'b0);
        expect1("req", 0); expect1("ready", 0); expect1("busy", 0);
        checkOutput("blocked");

        // Ack without a request is ignored.
        tick();
        applyStimulus(2'b00, 2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 1'b1);
        expect1("pulse", 0); expect1("kill", 0); expect1("req", 0);
        checkOutput("stray_ack");
        tick();
        idleInputs();
        expect1("busy", 0);
        checkOutput("stray_ack_after");

        // Lane-1 mispredict acknowledged immediately.
        tick();
        applyStimulus(2'b11, 2'b10, 0, 0, 32'h8000_0100, 32'h8, 1'b0, 0, 0, 1'b1);
        expect1("req", 1); expect1("op1", 32'h8000_0100); expect1("op2", 32'h8);
        expect1("ready", 2'b11); expect1("kill", 2'b00); expect1("pulse", 1);
        expect1("src", 0); expect1("busy", 0);
        checkOutput("l1_ack");
        tick();
        idleInputs();
        expect1("cnt", 2); expect1("req", 0); expect1("busy", 0);
        checkOutput("l1_ack_cnt");

        // Lane-0 flush, ack three cycles later, sources dropped meanwhile.
        tick();
        applyStimulus(2'b11, 2'b01, 32'h1000, 32'h4, 32'hAAAA, 32'hBBBB, 1'b0, 0, 0, 1'b0);
        expect1("req", 1); expect1("op1", 32'h1000); expect1("op2", 32'h4);
        expect1("ready", 2'b00); expect1("busy", 0); expect1("pulse", 0);
        checkOutput("l0_wait_c0");
        for (int c = 1; c <= 2; c++) begin
            tick();
            applyStimulus(2'b11, 2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 1'b0);
            expect1("req", 1); expect1("op1", 32'h1000); expect1("op2", 32'h4);
            expect1("ready", 2'b00); expect1("busy", 1); expect1("kill", 0);
            expect1("cnt", 0);
            checkOutput($sformatf("l0_wait_c%0d", c));
        end
        tick();
        applyStimulus(2'b11, 2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 1'b1);
        expect1("req", 1); expect1("op1", 32'h1000); expect1("op2", 32'h4);
        expect1("ready", 2'b01); expect1("kill", 2'b10); expect1("pulse", 1);
        expect1("src", 0); expect1("busy", 1);
        checkOutput("l0_ack");
        tick();
        idleInputs();
        expect1("busy", 0); expect1("req", 0); expect1("cnt", 1);
        checkOutput("l0_done");

        // Exception beats a lane flush.
        tick();
        applyStimulus(2'b11, 2'b01, 32'h5555, 32'h6666, 0, 0, 1'b1, 32'h2000_0000, 0, 1'b1);
        expect1("req", 1); expect1("op1", 32'h2000_0000); expect1("op2", 0);
        expect1("ready", 2'b00); expect1("kill", 2'b11); expect1("src", 1);
        expect1("pulse", 1);
        checkOutput("excp");
        tick();
        idleInputs();
        expect1("cnt", 0); expect1("src", 0); expect1("req", 0);
        checkOutput("excp_cnt");

        // No preemption of a lane flush by a later exception.
        tick();
        applyStimulus(2'b11, 2'b01, 32'h3000, 32'h4, 0, 0, 1'b0, 0, 0, 1'b0);
        expect1("req", 1); expect1("op1", 32'h3000);
        checkOutput("nopre_c0");
        tick();
        applyStimulus(2'b11, 2'b00, 0, 0, 0, 0, 1'b1, 32'h4000_0000, 32'h10, 1'b0);
        expect1("op1", 32'h3000); expect1("op2", 32'h4); expect1("src", 0);
        expect1("busy", 1); expect1("ready", 2'b00);
        checkOutput("nopre_wait");
        tick();
        applyStimulus(2'b11, 2'b00, 0, 0, 0, 0, 1'b1, 32'h4000_0000, 32'h10, 1'b1);
        expect1("op1", 32'h3000); expect1("pulse", 1); expect1("ready", 2'b01);
        expect1("kill", 2'b10); expect1("src", 0);
        checkOutput("nopre_ack");
        tick();
        applyStimulus(2'b00, 2'b00, 0, 0, 0, 0, 1'b1, 32'h4000_0000, 32'h10, 1'b1);
        expect1("req", 1); expect1("op1", 32'h4000_0000); expect1("op2", 32'h10);
        expect1("src", 1); expect1("busy", 0); expect1("ready", 0);
        expect1("kill", 2'b11); expect1("cnt", 1);
        checkOutput("nopre_excp");
        tick();
        idleInputs();
        expect1("req", 0); expect1("busy", 0); expect1("cnt", 0);
        checkOutput("nopre_done");

        // Reset while waiting for ack.
        tick();
        applyStimulus(2'b11, 2'b10, 0, 0, 32'h5000, 32'h8, 1'b0, 0, 0, 1'b0);
        expect1("req", 1); expect1("ready", 2'b01);
        checkOutput("rst_c0");
        tick();
        rst_n = 1'b0;
        expect1("busy", 1); expect1("cnt", 1); expect1("op1", 32'h5000);
        checkOutput("rst_wait");
        tick();
        rst_n = 1'b1;
        idleInputs();
        expect1("req", 0); expect1("busy", 0); expect1("cnt", 0); expect1("op1", 0);
        checkOutput("rst_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
